// File: rtl/paddle_pkg.sv
// Shared types and constants for the AY-3-8500 paddle scheduler.
// Sources pick where each player's per-frame bat position comes from.
package paddle_pkg;

  typedef enum logic [1:0] {
    SRC_DIGITAL = 2'd0,
    SRC_Y       = 2'd1,
    SRC_X       = 2'd2,
    SRC_PADDLE  = 2'd3
  } src_t;

  typedef enum logic {
    ST_DONE  = 1'b0,
    ST_COUNT = 1'b1
  } chan_state_t;

  localparam logic [7:0] DEF_STEP_SLOW = 8'd5;
  localparam logic [7:0] DEF_STEP_FAST = 8'd8;
  localparam logic [7:0] DEF_POS_INIT  = 8'd128;

  // Signed stick axis to offset-binary: -128 maps to 0, +127 maps to 255.
  function automatic logic [7:0] analog_to_u8(input logic [7:0] a);
    return {~a[7], a[6:0]};
  endfunction

endpackage

// File: rtl/paddle_channel.sv
// One player's channel: source mux, invert, digital integrator and the
// per-scanline down-counter whose expiry marks the bat position.
module paddle_channel
  import paddle_pkg::*;
#(
  parameter logic [7:0] STEP_SLOW = DEF_STEP_SLOW,
  parameter logic [7:0] STEP_FAST = DEF_STEP_FAST,
  parameter logic [7:0] POS_INIT  = DEF_POS_INIT
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        vs_rise,
  input  logic        hs_rise,
  input  logic        speed,
  input  src_t        src,
  input  logic        inv,
  input  logic        up,
  input  logic        down,
  input  logic [15:0] analog,
  input  logic [7:0]  paddle,
  output logic [7:0]  pos,
  output chan_state_t state
);

  chan_state_t state_nxt;
  logic [7:0]  count, count_nxt;
  logic [7:0]  sel, load;
  logic [8:0]  step, sum, diff;

  always_comb begin
    sel = pos;
    case (src)
      SRC_DIGITAL: sel = pos;
      SRC_Y:       sel = analog_to_u8(analog[15:8]);
      SRC_X:       sel = analog_to_u8(analog[7:0]);
      SRC_PADDLE:  sel = paddle;
      default:     sel = pos;
    endcase
    load = sel ^ {8{inv}};
  end

  // 9-bit arithmetic so the carry/borrow bit flags saturation.
  assign step = {1'b0, (speed ? STEP_FAST : STEP_SLOW)};
  assign sum  = {1'b0, pos} + step;
  assign diff = {1'b0, pos} - step;

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      pos <= POS_INIT;
    end else if (vs_rise && src == SRC_DIGITAL) begin
      if (down)    pos <= sum[8]  ? 8'hFF : sum[7:0];
      else if (up) pos <= diff[8] ? 8'h00 : diff[7:0];
    end
  end

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      state <= ST_DONE;
      count <= 8'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // A frame load always beats a coincident scanline decrement.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (vs_rise) begin
      count_nxt = load;
      state_nxt = (load != 8'd0) ? ST_COUNT : ST_DONE;
    end else if (hs_rise && state == ST_COUNT) begin
      count_nxt = count - 8'd1;
      state_nxt = (count == 8'd1) ? ST_DONE : ST_COUNT;
    end
  end

endmodule

// File: rtl/paddle_scheduler.sv
// Per-frame paddle scheduler feeding the AY-3-8500 pinLPin/pinRPin inputs.
// Sync edges are detected here and shared by both player channels.
module paddle_scheduler
  import paddle_pkg::*;
#(
  parameter logic [7:0] STEP_SLOW = DEF_STEP_SLOW,
  parameter logic [7:0] STEP_FAST = DEF_STEP_FAST,
  parameter logic [7:0] POS_INIT  = DEF_POS_INIT
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        hs,
  input  logic        vs,
  input  logic        speed,
  input  logic        practice,
  input  logic [1:0]  p1_src,
  input  logic [1:0]  p2_src,
  input  logic        p1_inv,
  input  logic        p2_inv,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  input  logic [15:0] p1_analog,
  input  logic [15:0] p2_analog,
  input  logic [7:0]  p1_paddle,
  input  logic [7:0]  p2_paddle,
  output logic        lp_in,
  output logic        rp_in,
  output logic [7:0]  p1_pos,
  output logic [7:0]  p2_pos
);

  logic        hs_d, vs_d, hs_rise, vs_rise;
  chan_state_t p1_state, p2_state;

  // Delays reset high so syncs held high through reset release are not edges.
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      hs_d <= 1'b1;
      vs_d <= 1'b1;
    end else begin
      hs_d <= hs;
      vs_d <= vs;
    end
  end

  assign hs_rise = hs & ~hs_d;
  assign vs_rise = vs & ~vs_d;

  paddle_channel #(
    .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST), .POS_INIT(POS_INIT)
  ) u_p1 (
    .clk_sys(clk_sys), .reset(reset), .vs_rise(vs_rise), .hs_rise(hs_rise),
    .speed(speed), .src(src_t'(p1_src)), .inv(p1_inv), .up(p1_up),
    .down(p1_down), .analog(p1_analog), .paddle(p1_paddle),
    .pos(p1_pos), .state(p1_state)
  );

  paddle_channel #(
    .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST), .POS_INIT(POS_INIT)
  ) u_p2 (
    .clk_sys(clk_sys), .reset(reset), .vs_rise(vs_rise), .hs_rise(hs_rise),
    .speed(speed), .src(src_t'(p2_src)), .inv(p2_inv), .up(p2_up),
    .down(p2_down), .analog(p2_analog), .paddle(p2_paddle),
    .pos(p2_pos), .state(p2_state)
  );

  always_comb begin
    lp_in = (p1_state == ST_DONE);
    rp_in = practice ? lp_in : (p2_state == ST_DONE);
  end

endmodule

// File: tb/tb_paddle_scheduler.sv
// Bench for paddle_scheduler: directed scenarios plus a randomized run
// compared against an arithmetic model of positions and scanline counts.
module tb_paddle_scheduler;

  logic        clk_sys = 1'b0;
  logic        reset, hs, vs, speed, practice;
  logic [1:0]  p1_src, p2_src;
  logic        p1_inv, p2_inv, p1_up, p1_down, p2_up, p2_down;
  logic [15:0] p1_analog, p2_analog;
  logic [7:0]  p1_paddle, p2_paddle;
  logic        lp_in, rp_in;
  logic [7:0]  p1_pos, p2_pos;

  int vectors = 0;
  int errors  = 0;
  int m_cnt[2];
  int m_pos[2];
  bit m_hs_d, m_vs_d;
  logic [17:0] exp_q[$];

  paddle_scheduler dut (
    .clk_sys(clk_sys), .reset(reset), .hs(hs), .vs(vs), .speed(speed),
    .practice(practice), .p1_src(p1_src), .p2_src(p2_src),
    .p1_inv(p1_inv), .p2_inv(p2_inv), .p1_up(p1_up), .p1_down(p1_down),
    .p2_up(p2_up), .p2_down(p2_down), .p1_analog(p1_analog),
    .p2_analog(p2_analog), .p1_paddle(p1_paddle), .p2_paddle(p2_paddle),
    .lp_in(lp_in), .rp_in(rp_in), .p1_pos(p1_pos), .p2_pos(p2_pos)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  // ---------------- reference model ----------------
  function automatic int sel_val(input logic [1:0] src, input logic [15:0] a,
                                 input logic [7:0] pad, input int pos, input logic inv);
    int v;
    case (src)
      2'd0:    v = pos;
      2'd1:    v = int'($signed(a[15:8])) + 128;
      2'd2:    v = int'($signed(a[7:0])) + 128;
      default: v = int'(pad);
    endcase
    return inv ? 255 - v : v;
  endfunction

  function automatic int move(input int p, input logic up, input logic dn, input int s);
    if (dn) return (p + s > 255) ? 255 : p + s;
    if (up) return (p - s < 0) ? 0 : p - s;
    return p;
  endfunction

  task automatic model_reset();
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_pos[0] = 128; m_pos[1] = 128;
    m_hs_d = 1'b1; m_vs_d = 1'b1;
  endtask

  task automatic model_update();
    bit vr, hr;
    int s;
    vr = vs && !m_vs_d;
    hr = hs && !m_hs_d;
    m_vs_d = vs;
    m_hs_d = hs;
    s = speed ? 8 : 5;
    if (vr) begin
      m_cnt[0] = sel_val(p1_src, p1_analog, p1_paddle, m_pos[0], p1_inv);
      m_cnt[1] = sel_val(p2_src, p2_analog, p2_paddle, m_pos[1], p2_inv);
      if (p1_src == 2'd0) m_pos[0] = move(m_pos[0], p1_up, p1_down, s);
      if (p2_src == 2'd0) m_pos[1] = move(m_pos[1], p2_up, p2_down, s);
    end else if (hr) begin
      for (int i = 0; i < 2; i++) if (m_cnt[i] > 0) m_cnt[i]--;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_sys); #1;
    model_update();
  endtask

  task automatic pulse_vs();
    vs = 1'b1; tick(); vs = 1'b0; tick();
  endtask

  task automatic pulse_hs();
    hs = 1'b1; tick(); hs = 1'b0; tick();
  endtask

  task automatic apply_reset();
    @(posedge clk_sys); #2;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_sys);
    #2 reset = 1'b1;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    hs = 1'b1; vs = 1'b1;
    apply_reset();
    tick(); tick();
    vectors++; if (lp_in !== 1'b1) begin errors++; $display("FAIL reset_lp: got %b want 1", lp_in); end
    vectors++; if (rp_in !== 1'b1) begin errors++; $display("FAIL reset_rp: got %b want 1", rp_in); end
    vectors++; if (p1_pos !== 8'd128) begin errors++; $display("FAIL reset_p1_pos: got %0d want 128", p1_pos); end
    vectors++; if (p2_pos !== 8'd128) begin errors++; $display("FAIL reset_p2_pos: got %0d want 128", p2_pos); end
    hs = 1'b0; vs = 1'b0;
    tick();
    vectors++; if (lp_in !== 1'b1) begin errors++; $display("FAIL reset_no_edge_lp: got %b want 1", lp_in); end
  endtask

  task automatic test_digital_count();
    p1_src = 2'd0; speed = 1'b0; p1_up = 1'b1;
    pulse_vs();
    p1_up = 1'b0;
    vectors++; if (p1_pos !== 8'd123) begin errors++; $display("FAIL dig_pos: got %0d want 123", p1_pos); end
    vectors++; if (lp_in !== 1'b0) begin errors++; $display("FAIL dig_load_lp: got %b want 0", lp_in); end
    for (int k = 1; k <= 128; k++) begin
      pulse_hs();
      vectors++;
      if (lp_in !== (k == 128)) begin errors++; $display("FAIL dig_count_lp k=%0d: got %b want %b", k, lp_in, (k == 128)); end
      vectors++;
      if (rp_in !== (k == 128)) begin errors++; $display("FAIL dig_count_rp k=%0d: got %b want %b", k, rp_in, (k == 128)); end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    p1_src = 2'd0; p2_src = 2'd3; p2_down = 1'b1;
    speed = 1'b0; p1_up = 1'b1;
    repeat (25) pulse_vs();
    vectors++; if (p1_pos !== 8'd3) begin errors++; $display("FAIL sat_reach3: got %0d want 3", p1_pos); end
    speed = 1'b1;
    pulse_vs();
    vectors++; if (p1_pos !== 8'd0) begin errors++; $display("FAIL sat_low: got %0d want 0", p1_pos); end
    p1_up = 1'b0; p1_down = 1'b1;
    repeat (30) pulse_vs();
    speed = 1'b0;
    repeat (2) pulse_vs();
    vectors++; if (p1_pos !== 8'd250) begin errors++; $display("FAIL sat_reach250: got %0d want 250", p1_pos); end
    pulse_vs();
    vectors++; if (p1_pos !== 8'd255) begin errors++; $display("FAIL sat_high: got %0d want 255", p1_pos); end
    vectors++; if (p2_pos !== 8'd128) begin errors++; $display("FAIL sat_p2_hold: got %0d want 128", p2_pos); end
    apply_reset();
    p1_up = 1'b1; p1_down = 1'b1;
    pulse_vs();
    vectors++; if (p1_pos !== 8'd133) begin errors++; $display("FAIL sat_both: got %0d want 133", p1_pos); end
    p1_up = 1'b0; p1_down = 1'b0; p2_down = 1'b0; p2_src = 2'd0;
  endtask

  task automatic test_analog();
    p1_src = 2'd1; p1_analog = 16'h8000; p1_inv = 1'b0;
    pulse_vs();
    vectors++; if (lp_in !== 1'b1) begin errors++; $display("FAIL ana_zero_load: got %b want 1", lp_in); end
    repeat (3) begin
      pulse_hs();
      vectors++; if (lp_in !== 1'b1) begin errors++; $display("FAIL ana_zero_hold: got %b want 1", lp_in); end
    end
    p1_inv = 1'b1;
    pulse_vs();
    for (int k = 1; k <= 255; k++) begin
      pulse_hs();
      vectors++;
      if (lp_in !== (k == 255)) begin errors++; $display("FAIL ana_inv k=%0d: got %b want %b", k, lp_in, (k == 255)); end
    end
    p1_inv = 1'b0; p1_src = 2'd2; p1_analog = 16'h0040;
    pulse_vs();
    for (int k = 1; k <= 192; k++) begin
      pulse_hs();
      vectors++;
      if (lp_in !== (k == 192)) begin errors++; $display("FAIL ana_x k=%0d: got %b want %b", k, lp_in, (k == 192)); end
    end
  endtask

  task automatic test_practice();
    p1_src = 2'd3; p1_paddle = 8'd10; p2_src = 2'd3; p2_paddle = 8'd200;
    practice = 1'b1;
    pulse_vs();
    for (int k = 1; k <= 12; k++) begin
      pulse_hs();
      vectors++;
      if (lp_in !== (k >= 10)) begin errors++; $display("FAIL prac_lp k=%0d: got %b want %b", k, lp_in, (k >= 10)); end
      vectors++;
      if (rp_in !== (k >= 10)) begin errors++; $display("FAIL prac_rp k=%0d: got %b want %b", k, rp_in, (k >= 10)); end
    end
    practice = 1'b0;
    #1;
    vectors++; if (rp_in !== 1'b0) begin errors++; $display("FAIL prac_off_rp: got %b want 0", rp_in); end
  endtask

  task automatic test_coincident();
    p1_src = 2'd3; p1_paddle = 8'd20;
    pulse_vs();
    repeat (5) pulse_hs();
    hs = 1'b1; vs = 1'b1; tick();
    hs = 1'b0; vs = 1'b0; tick();
    vectors++; if (lp_in !== 1'b0) begin errors++; $display("FAIL coin_load: got %b want 0", lp_in); end
    for (int k = 1; k <= 20; k++) begin
      pulse_hs();
      vectors++;
      if (lp_in !== (k == 20)) begin errors++; $display("FAIL coin_count k=%0d: got %b want %b", k, lp_in, (k == 20)); end
    end
  endtask

  task automatic test_reset_midcount();
    p1_src = 2'd3; p1_paddle = 8'd60; p2_src = 2'd3; p2_paddle = 8'd90;
    pulse_vs();
    repeat (10) pulse_hs();
    vectors++; if (lp_in !== 1'b0) begin errors++; $display("FAIL rmid_pre: got %b want 0", lp_in); end
    @(posedge clk_sys); #3;
    reset = 1'b0;
    model_reset();
    #1;
    vectors++; if (lp_in !== 1'b1) begin errors++; $display("FAIL rmid_async_lp: got %b want 1", lp_in); end
    vectors++; if (rp_in !== 1'b1) begin errors++; $display("FAIL rmid_async_rp: got %b want 1", rp_in); end
    @(posedge clk_sys); #2;
    reset = 1'b1;
    tick();
    repeat (3) begin
      pulse_hs();
      vectors++; if (lp_in !== 1'b1) begin errors++; $display("FAIL rmid_wait: got %b want 1", lp_in); end
    end
    pulse_vs();
    vectors++; if (lp_in !== 1'b0) begin errors++; $display("FAIL rmid_reload: got %b want 0", lp_in); end
  endtask

  task automatic test_random();
    logic [17:0] exp_v, got_v;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        p1_src = 2'($urandom_range(0, 3)); p2_src = 2'($urandom_range(0, 3));
        p1_inv = ($urandom_range(0, 3) == 0); p2_inv = ($urandom_range(0, 3) == 0);
        speed = 1'($urandom_range(0, 1)); practice = ($urandom_range(0, 3) == 0);
        p1_analog = 16'($urandom); p2_analog = 16'($urandom);
        p1_paddle = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
        p2_paddle = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      end
      p1_up = 1'($urandom_range(0, 1)); p1_down = ($urandom_range(0, 2) == 0);
      p2_up = 1'($urandom_range(0, 1)); p2_down = ($urandom_range(0, 2) == 0);
      hs = 1'($urandom_range(0, 1));
      vs = ($urandom_range(0, 59) == 0);
      tick();
      exp_q.push_back({(m_cnt[0] == 0), (practice ? (m_cnt[0] == 0) : (m_cnt[1] == 0)),
                       8'(m_pos[0]), 8'(m_pos[1])});
      got_v = {lp_in, rp_in, p1_pos, p2_pos};
      exp_v = exp_q.pop_front();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random c=%0d: got lp=%b rp=%b p1=%0d p2=%0d want lp=%b rp=%b p1=%0d p2=%0d",
                 c, got_v[17], got_v[16], got_v[15:8], got_v[7:0],
                 exp_v[17], exp_v[16], exp_v[15:8], exp_v[7:0]);
      end
    end
    hs = 1'b0; vs = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0; hs = 1'b1; vs = 1'b1; speed = 1'b0; practice = 1'b0;
    p1_src = 2'd0; p2_src = 2'd0; p1_inv = 1'b0; p2_inv = 1'b0;
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
    p1_analog = 16'h0000; p2_analog = 16'h0000; p1_paddle = 8'd0; p2_paddle = 8'd0;
    model_reset();
    test_reset();
    test_digital_count();
    test_saturation();
    test_analog();
    test_practice();
    test_coincident();
    test_reset_midcount();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
